// File: rtl/bp_me_pkg.sv
// Shared types and header-field geometry for the coherence link repeater.
// Flit, cord and length widths stand in for the processor-config-derived NoC widths.
package bp_me_pkg;

    localparam int coh_noc_flit_width_p = 32;
    localparam int coh_noc_cord_width_p = 8;
    localparam int coh_noc_len_width_p  = 4;

    localparam int hdr_cord_offset_lp = 0;
    localparam int hdr_len_offset_lp  = coh_noc_cord_width_p;

    typedef enum logic {e_wh_idle, e_wh_body} bp_wh_track_state_e;

    // ready_and link bundle: valid, payload, and the reverse-direction ready
    typedef struct packed {
        logic                            v;
        logic [coh_noc_flit_width_p-1:0] data;
        logic                            ready_and_rev;
    } bp_ral_link_s;

    function automatic logic [coh_noc_len_width_p-1:0] hdr_len(
        input logic [coh_noc_flit_width_p-1:0] flit
    );
        return flit[hdr_len_offset_lp +: coh_noc_len_width_p];
    endfunction

endpackage

// File: rtl/bp_coh_link_fifo.sv
// Small 1-read/1-write FIFO without enqueue-on-full bypass.
module bp_coh_link_fifo #(
    parameter int width_p = 32,
    parameter int els_p   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               full_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);
    localparam int ptr_w = $clog2(els_p);
    localparam int cnt_w = $clog2(els_p + 1);

    logic [width_p-1:0] mem [els_p];
    logic [ptr_w-1:0]   wptr, rptr;
    logic [cnt_w-1:0]   count;
    logic               enq, deq;

    function automatic logic [ptr_w-1:0] nxt(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o = (count == cnt_w'(els_p));
    assign v_o    = (count != '0);
    assign data_o = mem[rptr];
    assign enq    = v_i & ~full_o;
    assign deq    = yumi_i & v_o;

    always_ff @(posedge clk) begin
        if (enq) mem[wptr] <= data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (enq) wptr <= nxt(wptr);
            if (deq) rptr <= nxt(rptr);
            if (enq && !deq)      count <= count + 1'b1;
            else if (!enq && deq) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/bp_coh_wormhole_tracker.sv
// Tracks wormhole packet boundaries on one link direction and gates input ready
// so a fence can only take effect between packets.
module bp_coh_wormhole_tracker
    import bp_me_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            v_i,
    input  logic                            ready_i,
    input  logic [coh_noc_flit_width_p-1:0] data_i,
    input  logic                            fence_i,
    output logic                            ready_and_o,
    output logic                            idle_o,
    output logic                            hdr_accept_o
);
    // state     | meaning
    // e_wh_idle | next accepted flit is a header; fence may block it
    // e_wh_body | body flits outstanding; fence ignored until packet ends

    bp_wh_track_state_e               state;
    logic [coh_noc_len_width_p-1:0]   remaining;
    logic                             accept;
    logic                             unused_data;

    assign unused_data  = ^data_i;
    assign idle_o       = (state == e_wh_idle);
    assign ready_and_o  = ready_i & ~(fence_i & idle_o);
    assign accept       = v_i & ready_and_o;
    assign hdr_accept_o = accept & idle_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= e_wh_idle;
            remaining <= '0;
        end else if (accept) begin
            case (state)
                e_wh_idle: begin
                    if (hdr_len(data_i) != '0) begin
                        state     <= e_wh_body;
                        remaining <= hdr_len(data_i);
                    end
                end
                e_wh_body: begin
                    remaining <= remaining - 1'b1;
                    if (remaining == coh_noc_len_width_p'(1))
                        state <= e_wh_idle;
                end
                default: state <= e_wh_idle;
            endcase
        end
    end

endmodule

// File: rtl/bp_coh_link_fence_repeater.sv
// Bidirectional retiming repeater for one coherence link with a packet-boundary fence.
// Define BP_COH_LINK_PKT_CNT_EN to build the per-direction header counters.
module bp_coh_link_fence_repeater
    import bp_me_pkg::*;
#(
    parameter int els_p       = 2,
    parameter int cnt_width_p = 32
) (
    input  logic                   coh_clk_i,
    input  logic                   coh_reset_n_i,
    input  bp_ral_link_s           west_link_i,
    output bp_ral_link_s           west_link_o,
    input  bp_ral_link_s           east_link_i,
    output bp_ral_link_s           east_link_o,
    input  logic                   fence_i,
    output logic                   fence_ack_o,
    output logic [cnt_width_p-1:0] pkt_cnt_we_o,
    output logic [cnt_width_p-1:0] pkt_cnt_ew_o
);
    localparam int fw = coh_noc_flit_width_p;

    logic          link_en;
    logic          full_we, full_ew, fv_we, fv_ew;
    logic          rdy_we, rdy_ew, idle_we, idle_ew, hdr_we, hdr_ew;
    logic [fw-1:0] fdata_we, fdata_ew;

    // keeps both inputs not-ready until the first clock after reset release
    always_ff @(posedge coh_clk_i or negedge coh_reset_n_i) begin
        if (!coh_reset_n_i) link_en <= 1'b0;
        else                link_en <= 1'b1;
    end

    bp_coh_wormhole_tracker trk_we (
        .clk(coh_clk_i), .rst_n(coh_reset_n_i),
        .v_i(west_link_i.v), .ready_i(link_en & ~full_we), .data_i(west_link_i.data),
        .fence_i(fence_i), .ready_and_o(rdy_we), .idle_o(idle_we), .hdr_accept_o(hdr_we)
    );

    bp_coh_wormhole_tracker trk_ew (
        .clk(coh_clk_i), .rst_n(coh_reset_n_i),
        .v_i(east_link_i.v), .ready_i(link_en & ~full_ew), .data_i(east_link_i.data),
        .fence_i(fence_i), .ready_and_o(rdy_ew), .idle_o(idle_ew), .hdr_accept_o(hdr_ew)
    );

    bp_coh_link_fifo #(.width_p(fw), .els_p(els_p)) fifo_we (
        .clk(coh_clk_i), .rst_n(coh_reset_n_i),
        .v_i(west_link_i.v & rdy_we), .data_i(west_link_i.data), .full_o(full_we),
        .v_o(fv_we), .data_o(fdata_we), .yumi_i(fv_we & east_link_i.ready_and_rev)
    );

    bp_coh_link_fifo #(.width_p(fw), .els_p(els_p)) fifo_ew (
        .clk(coh_clk_i), .rst_n(coh_reset_n_i),
        .v_i(east_link_i.v & rdy_ew), .data_i(east_link_i.data), .full_o(full_ew),
        .v_o(fv_ew), .data_o(fdata_ew), .yumi_i(fv_ew & west_link_i.ready_and_rev)
    );

    assign east_link_o.v             = fv_we;
    assign east_link_o.data          = fdata_we;
    assign east_link_o.ready_and_rev = rdy_ew;
    assign west_link_o.v             = fv_ew;
    assign west_link_o.data          = fdata_ew;
    assign west_link_o.ready_and_rev = rdy_we;

    always_ff @(posedge coh_clk_i or negedge coh_reset_n_i) begin
        if (!coh_reset_n_i) fence_ack_o <= 1'b0;
        else                fence_ack_o <= fence_i & idle_we & idle_ew & ~fv_we & ~fv_ew;
    end

`ifdef BP_COH_LINK_PKT_CNT_EN
    logic [cnt_width_p-1:0] cnt_we, cnt_ew;

    always_ff @(posedge coh_clk_i or negedge coh_reset_n_i) begin
        if (!coh_reset_n_i) begin
            cnt_we <= '0;
            cnt_ew <= '0;
        end else begin
            if (hdr_we) cnt_we <= cnt_we + 1'b1;
            if (hdr_ew) cnt_ew <= cnt_ew + 1'b1;
        end
    end

    assign pkt_cnt_we_o = cnt_we;
    assign pkt_cnt_ew_o = cnt_ew;
`else
    logic unused_hdr;
    assign unused_hdr   = hdr_we ^ hdr_ew;
    assign pkt_cnt_we_o = '0;
    assign pkt_cnt_ew_o = '0;
`endif

endmodule
